// File: rtl/cond_pkg.sv
// Shared definitions for ARM condition evaluation: condition-code encoding
// and bit positions of the {N,Z,C,V} flag vector.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Pure combinational ARM condition check of a 4-bit condition field against
// an {N,Z,C,V} flag vector; shared with the single-cycle datapath.
module cond_check
  import cond_pkg::*;
#(
  parameter bit NV_EXEC = 1'b0
) (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_true
);

  logic n, z, c, v;

  always_comb begin
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    cond_true = 1'b0;
    case (cond_t'(cond))
      COND_EQ: cond_true = z;
      COND_NE: cond_true = ~z;
      COND_CS: cond_true = c;
      COND_CC: cond_true = ~c;
      COND_MI: cond_true = n;
      COND_PL: cond_true = ~n;
      COND_VS: cond_true = v;
      COND_VC: cond_true = ~v;
      COND_HI: cond_true = c & ~z;
      COND_LS: cond_true = ~c | z;
      COND_GE: cond_true = (n == v);
      COND_LT: cond_true = (n != v);
      COND_GT: cond_true = ~z & (n == v);
      COND_LE: cond_true = z | (n != v);
      COND_AL: cond_true = 1'b1;
      COND_NV: cond_true = NV_EXEC;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition unit: architectural NZCV register, condition
// gating of PCSrc/RegWrite/MemWrite, and the Execute->Memory control register.
module cond_unit
  import cond_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter bit         NV_EXEC     = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ValidE,
  input  logic       StallE,
  input  logic       FlushE,
  input  logic [3:0] CondE,
  input  logic [3:0] ALUFlagsE,
  input  logic [1:0] FlagWE,
  input  logic       PCSE,
  input  logic       RegWE,
  input  logic       MemWE,
  input  logic       NoWriteE,
  output logic       CondExE,
  output logic       PCSrcE,
  output logic       PCSrcM,
  output logic       RegWriteM,
  output logic       MemWriteM,
  output logic       IllegalCondM,
  output logic [3:0] Flags
);

  logic       cond_true;
  logic       reg_write_g, mem_write_g, illegal_e;
  logic [3:0] flags_d, flags_q;
  logic       pcsrc_m_d, pcsrc_m_q;
  logic       reg_write_m_d, reg_write_m_q;
  logic       mem_write_m_d, mem_write_m_q;
  logic       illegal_m_d, illegal_m_q;

  // Evaluated against the stored flags only; no bypass from ALUFlagsE.
  cond_check #(.NV_EXEC(NV_EXEC)) u_cond_check (
    .cond      (CondE),
    .flags     (flags_q),
    .cond_true (cond_true)
  );

  always_comb begin
    CondExE     = ValidE & ~FlushE & cond_true;
    PCSrcE      = PCSE & CondExE;
    reg_write_g = RegWE & CondExE & ~NoWriteE;
    mem_write_g = MemWE & CondExE;
    illegal_e   = ValidE & ~FlushE & (CondE == COND_NV) & ~NV_EXEC;

    flags_d = flags_q;
    if (CondExE & ~StallE) begin
      if (FlagWE[1]) begin
        flags_d[FLAG_N] = ALUFlagsE[FLAG_N];
        flags_d[FLAG_Z] = ALUFlagsE[FLAG_Z];
      end
      if (FlagWE[0]) begin
        flags_d[FLAG_C] = ALUFlagsE[FLAG_C];
        flags_d[FLAG_V] = ALUFlagsE[FLAG_V];
      end
    end

    // Flush beats stall: a squashed instruction must not linger in Memory.
    pcsrc_m_d     = pcsrc_m_q;
    reg_write_m_d = reg_write_m_q;
    mem_write_m_d = mem_write_m_q;
    illegal_m_d   = illegal_m_q;
    if (FlushE) begin
      pcsrc_m_d     = 1'b0;
      reg_write_m_d = 1'b0;
      mem_write_m_d = 1'b0;
      illegal_m_d   = 1'b0;
    end else if (!StallE) begin
      pcsrc_m_d     = PCSrcE;
      reg_write_m_d = reg_write_g;
      mem_write_m_d = mem_write_g;
      illegal_m_d   = illegal_e;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q       <= RESET_FLAGS;
      pcsrc_m_q     <= 1'b0;
      reg_write_m_q <= 1'b0;
      mem_write_m_q <= 1'b0;
      illegal_m_q   <= 1'b0;
    end else begin
      flags_q       <= flags_d;
      pcsrc_m_q     <= pcsrc_m_d;
      reg_write_m_q <= reg_write_m_d;
      mem_write_m_q <= mem_write_m_d;
      illegal_m_q   <= illegal_m_d;
    end
  end

  assign Flags        = flags_q;
  assign PCSrcM       = pcsrc_m_q;
  assign RegWriteM    = reg_write_m_q;
  assign MemWriteM    = mem_write_m_q;
  assign IllegalCondM = illegal_m_q;

endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_cond_unit;

  localparam logic [3:0] RST_FLAGS = 4'b0000;
  localparam bit         NV_EN     = 1'b0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ValidE = 1'b0, StallE = 1'b0, FlushE = 1'b0;
  logic [3:0] CondE = 4'b1110, ALUFlagsE = 4'b0000;
  logic [1:0] FlagWE = 2'b00;
  logic       PCSE = 1'b0, RegWE = 1'b0, MemWE = 1'b0, NoWriteE = 1'b0;
  logic       CondExE, PCSrcE, PCSrcM, RegWriteM, MemWriteM, IllegalCondM;
  logic [3:0] Flags;

  int n_cmp = 0;
  int n_bad = 0;

  cond_unit #(.RESET_FLAGS(RST_FLAGS), .NV_EXEC(NV_EN)) dut (
    .clk(clk), .reset(reset), .ValidE(ValidE), .StallE(StallE), .FlushE(FlushE),
    .CondE(CondE), .ALUFlagsE(ALUFlagsE), .FlagWE(FlagWE), .PCSE(PCSE),
    .RegWE(RegWE), .MemWE(MemWE), .NoWriteE(NoWriteE), .CondExE(CondExE),
    .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .IllegalCondM(IllegalCondM), .Flags(Flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ARM rule: bits [3:1] pick a base test, bit 0 inverts it; 1111 is special.
  function automatic bit cond_holds(input logic [3:0] code, input logic [3:0] f);
    bit n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    if (code == 4'hF) return NV_EN;
    case (code[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ code[0];
  endfunction

  // Behavioural model state
  bit         m_valid = 1'b0;
  logic [3:0] m_flags;
  logic       m_pcs, m_rw, m_mw, m_ill;

  function automatic bit m_ce();
    return ValidE && !FlushE && cond_holds(CondE, m_flags);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1;
      m_flags = RST_FLAGS;
      {m_pcs, m_rw, m_mw, m_ill} = 4'b0000;
    end else if (m_valid) begin
      bit ce;
      ce = m_ce();
      if (FlushE) {m_pcs, m_rw, m_mw, m_ill} = 4'b0000;
      else if (!StallE) begin
        m_pcs = ce && PCSE;
        m_rw  = ce && RegWE && !NoWriteE;
        m_mw  = ce && MemWE;
        m_ill = ValidE && (CondE == 4'hF) && !NV_EN;
      end
      if (ce && !StallE) begin
        if (FlagWE[1]) m_flags[3:2] = ALUFlagsE[3:2];
        if (FlagWE[0]) m_flags[1:0] = ALUFlagsE[1:0];
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("CondExE", {3'b0, CondExE}, {3'b0, m_ce()});
      check("PCSrcE", {3'b0, PCSrcE}, {3'b0, m_ce() && PCSE});
      check("PCSrcM", {3'b0, PCSrcM}, {3'b0, m_pcs});
      check("RegWriteM", {3'b0, RegWriteM}, {3'b0, m_rw});
      check("MemWriteM", {3'b0, MemWriteM}, {3'b0, m_mw});
      check("IllegalCondM", {3'b0, IllegalCondM}, {3'b0, m_ill});
      check("Flags", Flags, m_flags);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic f, input logic [3:0] c,
                       input logic [3:0] alu, input logic [1:0] fwe, input logic pcs,
                       input logic rw, input logic mw, input logic nw);
    ValidE = v; StallE = s; FlushE = f; CondE = c; ALUFlagsE = alu; FlagWE = fwe;
    PCSE = pcs; RegWE = rw; MemWE = mw; NoWriteE = nw;
  endtask

  initial begin
    step(); step();
    reset = 1'b0;
    check("lit_reset_flags", Flags, 4'b0000);
    check("lit_reset_m", {PCSrcM, RegWriteM, MemWriteM, IllegalCondM}, 4'b0000);

    // AL with flag write
    drive(1, 0, 0, 4'b1110, 4'b0110, 2'b11, 0, 1, 0, 0);
    #1 check("lit_al_condex", {3'b0, CondExE}, 4'b0001);
    step();
    check("lit_al_regwm", {3'b0, RegWriteM}, 4'b0001);
    check("lit_al_flags", Flags, 4'b0110);

    // Failed NE with Z=1 must not write flags or memory
    drive(1, 0, 0, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0);
    step();
    check("lit_setz", Flags, 4'b0100);
    drive(1, 0, 0, 4'b0001, 4'b1000, 2'b11, 0, 0, 1, 0);
    #1 check("lit_ne_condex", {3'b0, CondExE}, 4'b0000);
    step();
    check("lit_ne_memwm", {3'b0, MemWriteM}, 4'b0000);
    check("lit_ne_flags", Flags, 4'b0100);
    drive(1, 0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0);
    #1 check("lit_eq_condex", {3'b0, CondExE}, 4'b0001);
    step();

    // Partial flag writes
    drive(1, 0, 0, 4'b1110, 4'b0011, 2'b11, 0, 0, 0, 0);
    step();
    drive(1, 0, 0, 4'b1110, 4'b1100, 2'b10, 0, 0, 0, 0);
    step();
    check("lit_fwe10", Flags, 4'b1111);
    drive(1, 0, 0, 4'b1110, 4'b0000, 2'b01, 0, 0, 0, 0);
    step();
    check("lit_fwe01", Flags, 4'b1100);

    // Stall freezes, flush overrides stall
    drive(1, 0, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);
    step();
    drive(1, 1, 0, 4'b1110, 4'b1111, 2'b11, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("lit_stall_regwm", {3'b0, RegWriteM}, 4'b0000);
      check("lit_stall_flags", Flags, 4'b1100);
    end
    drive(1, 0, 0, 4'b1110, 4'b0000, 2'b00, 0, 1, 0, 0);
    step();
    check("lit_prefl_regwm", {3'b0, RegWriteM}, 4'b0001);
    drive(1, 1, 1, 4'b1110, 4'b1111, 2'b11, 0, 1, 0, 0);
    #1 check("lit_flush_condex", {3'b0, CondExE}, 4'b0000);
    step();
    check("lit_flush_regwm", {3'b0, RegWriteM}, 4'b0000);
    check("lit_flush_flags", Flags, 4'b1100);

    // CMP then BEQ back-to-back
    drive(1, 0, 0, 4'b1110, 4'b0110, 2'b11, 0, 1, 0, 1);
    step();
    check("lit_cmp_regwm", {3'b0, RegWriteM}, 4'b0000);
    check("lit_cmp_flags", Flags, 4'b0110);
    drive(1, 0, 0, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0);
    #1 check("lit_beq_pcsrce", {3'b0, PCSrcE}, 4'b0001);
    step();
    check("lit_beq_pcsrcm", {3'b0, PCSrcM}, 4'b0001);

    // Full condition sweep over every flag value
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        drive(1, 0, 0, 4'b1110, 4'(f), 2'b11, 0, 0, 0, 0);
        step();
        drive(1, 0, 0, 4'(c), 4'(~f), 2'b11, 0, 0, 0, 0);
        #1 check("sweep_condex", {3'b0, CondExE}, {3'b0, cond_holds(4'(c), 4'(f))});
        step();
        check("sweep_illegal", {3'b0, IllegalCondM}, {3'b0, c == 15});
      end
    end

    // Randomized traffic; the negedge process does the checking
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), $urandom_range(0, 3) == 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
